pke_op_seq: RTL and testbench

PKE_OP_SEQ -- requirements
Module: pke_op_seq

---
 rtl/pke_pkg.sv | 27 ++
 rtl/pke_op_seq_if.sv | 46 ++++
 rtl/pke_cmd_fifo.sv | 56 +++++
 rtl/pke_op_seq.sv | 121 ++++++++++++
 tb/tb_pke_op_seq.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pke_pkg.sv
// Shared types for the PKE operation sequencer: FSM states, the queued command
// record and the engine-select encoding.
package pke_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StStart = 3'd2,
        StWait  = 3'd3,
        StGap   = 3'd4
    } pke_state_e;

    // 34-bit command record: op, three RAM word addresses and the mode bits.
    typedef struct packed {
        logic [3:0] op;
        logic [8:0] src0;
        logic [8:0] src1;
        logic [8:0] dst;
        logic       rsa;
        logic       exp;
        logic       mimm;
    } pke_cmd_t;

    localparam logic EngBasic  = 1'b0;
    localparam logic EngModMul = 1'b1;

endpackage

// File: rtl/pke_op_seq_if.sv
// Command, engine and status bundle of the PKE sequencer. The slave modport is the
// sequencer; the master modport is the command source plus the two engines.
interface pke_op_seq_if;

    logic       CmdValid;
    logic       CmdReady;
    logic [3:0] CmdOp;
    logic [8:0] CmdSrc0Adr;
    logic [8:0] CmdSrc1Adr;
    logic [8:0] CmdDstAdr;
    logic       CmdRsa;
    logic       CmdExp;
    logic       CmdMimm;
    logic       BasicStart;
    logic       ModMulStart;
    logic       BasicDone;
    logic       ModMulDone;
    logic [2:0] EngOp;
    logic [8:0] Src0Adr;
    logic [8:0] Src1Adr;
    logic [8:0] DstAdr;
    logic       RsaMode;
    logic       ExpMode;
    logic       MimmMode;
    logic       Abort;
    logic       Busy;
    logic       OpDone;
    logic       ErrSpur;
    logic       ErrTmo;
    logic       ErrClr;

    modport slave (
        input  CmdValid, CmdOp, CmdSrc0Adr, CmdSrc1Adr, CmdDstAdr, CmdRsa, CmdExp, CmdMimm,
        input  BasicDone, ModMulDone, Abort, ErrClr,
        output CmdReady, BasicStart, ModMulStart, EngOp, Src0Adr, Src1Adr, DstAdr,
        output RsaMode, ExpMode, MimmMode, Busy, OpDone, ErrSpur, ErrTmo
    );

    modport master (
        output CmdValid, CmdOp, CmdSrc0Adr, CmdSrc1Adr, CmdDstAdr, CmdRsa, CmdExp, CmdMimm,
        output BasicDone, ModMulDone, Abort, ErrClr,
        input  CmdReady, BasicStart, ModMulStart, EngOp, Src0Adr, Src1Adr, DstAdr,
        input  RsaMode, ExpMode, MimmMode, Busy, OpDone, ErrSpur, ErrTmo
    );

endinterface

// File: rtl/pke_cmd_fifo.sv
// Synchronous command FIFO; Depth must be a power of two so pointers wrap for free.
module pke_cmd_fifo
    import pke_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    input  logic     push,
    input  pke_cmd_t wdata,
    input  logic     pop,
    output pke_cmd_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PtrW = $clog2(Depth);

    pke_cmd_t        mem [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            do_push, do_pop;

    // count reaches Depth exactly when its top bit sets
    assign full    = count_q[PtrW];
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/pke_op_seq.sv
// PKE operation sequencer: queues commands and drives the Basic/ModMul engines.
// Optional WAIT timeout enabled by defining PKE_SEQ_TIMEOUT_EN.
module pke_op_seq
    import pke_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYC = 16'd4096,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input logic         Clk,
    input logic         Resetn,
    pke_op_seq_if.slave bus
);

    pke_state_e state_q, state_d;
    pke_cmd_t   push_cmd, head_cmd;
    logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic       eng_sel_q;
    logic       active_done, other_done, spur_ev, tmo_hit;
    logic       op_done_q, err_spur_q;

    assign push_cmd = '{op: bus.CmdOp, src0: bus.CmdSrc0Adr, src1: bus.CmdSrc1Adr,
                        dst: bus.CmdDstAdr, rsa: bus.CmdRsa, exp: bus.CmdExp,
                        mimm: bus.CmdMimm};

    assign bus.CmdReady = ~fifo_full & ~bus.Abort;
    assign fifo_push    = bus.CmdValid & bus.CmdReady;
    assign fifo_pop     = (state_q == StLoad);

    pke_cmd_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (Resetn),
        .flush (bus.Abort),
        .push  (fifo_push),
        .wdata (push_cmd),
        .pop   (fifo_pop),
        .rdata (head_cmd),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign active_done = (eng_sel_q == EngModMul) ? bus.ModMulDone : bus.BasicDone;
    assign other_done  = (eng_sel_q == EngModMul) ? bus.BasicDone : bus.ModMulDone;
    // Outside WAIT any Done is unexpected; inside WAIT only the idle engine's is.
    assign spur_ev     = (state_q == StWait) ? other_done : (bus.BasicDone | bus.ModMulDone);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!fifo_empty) state_d = StLoad;
            StLoad:  state_d = StStart;
            StStart: state_d = StWait;
            StWait:  if (active_done || tmo_hit) state_d = StGap;
            StGap:   state_d = fifo_empty ? StIdle : StLoad;
            default: state_d = StIdle;
        endcase
        if (bus.Abort) state_d = StIdle;
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= StIdle;
            eng_sel_q    <= EngBasic;
            bus.EngOp    <= '0;
            bus.Src0Adr  <= '0;
            bus.Src1Adr  <= '0;
            bus.DstAdr   <= '0;
            bus.RsaMode  <= 1'b0;
            bus.ExpMode  <= 1'b0;
            bus.MimmMode <= 1'b0;
            op_done_q    <= 1'b0;
            err_spur_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_done_q  <= (state_q == StWait) & active_done & ~bus.Abort;
            err_spur_q <= spur_ev | (err_spur_q & ~bus.ErrClr);
            if (state_q == StLoad) begin
                eng_sel_q    <= head_cmd.op[3];
                bus.EngOp    <= head_cmd.op[2:0];
                bus.Src0Adr  <= head_cmd.src0;
                bus.Src1Adr  <= head_cmd.src1;
                bus.DstAdr   <= head_cmd.dst;
                bus.RsaMode  <= head_cmd.rsa;
                bus.ExpMode  <= head_cmd.exp;
                bus.MimmMode <= head_cmd.mimm;
            end
        end
    end

`ifdef PKE_SEQ_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        err_tmo_q;

    assign tmo_cnt_d = (state_q == StWait) ? tmo_cnt_q + 16'd1 : 16'd0;
    // A Done arriving on the final cycle still completes the op normally.
    assign tmo_hit   = (state_q == StWait) & ~active_done & (tmo_cnt_d == TIMEOUT_CYC);

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            tmo_cnt_q <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_tmo_q <= tmo_hit | (err_tmo_q & ~bus.ErrClr);
        end
    end

    assign bus.ErrTmo = err_tmo_q;
`else
    assign tmo_hit    = 1'b0;
    assign bus.ErrTmo = 1'b0;
`endif

    assign bus.BasicStart  = (state_q == StStart) & (eng_sel_q == EngBasic);
    assign bus.ModMulStart = (state_q == StStart) & (eng_sel_q == EngModMul);
    assign bus.Busy        = ~fifo_empty | (state_q != StIdle);
    assign bus.OpDone      = op_done_q;
    assign bus.ErrSpur     = err_spur_q;

endmodule

// File: tb/tb_pke_op_seq.sv
// Directed bench for pke_op_seq: single op, back-to-back queueing, spurious Done,
// abort, reset mid-op and (when PKE_SEQ_TIMEOUT_EN is defined) WAIT timeout.
module tb_pke_op_seq;

    logic Clk;
    logic Resetn;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   n_bstart = 0;
    int   n_mstart = 0;
    int   n_opdone = 0;

    pke_op_seq_if bus ();

    pke_op_seq #(
        .TIMEOUT_CYC (16'd16),
        .FIFO_DEPTH  (2)
    ) dut (
        .Clk    (Clk),
        .Resetn (Resetn),
        .bus    (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (bus.BasicStart)  n_bstart <= n_bstart + 1;
        if (bus.ModMulStart) n_mstart <= n_mstart + 1;
        if (bus.OpDone)      n_opdone <= n_opdone + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns on the next falling edge with valid dropped.
    task automatic push(input logic [3:0] op, input logic [8:0] s0, input logic [8:0] s1,
                        input logic [8:0] d);
        bus.CmdValid   = 1'b1;
        bus.CmdOp      = op;
        bus.CmdSrc0Adr = s0;
        bus.CmdSrc1Adr = s1;
        bus.CmdDstAdr  = d;
        @(negedge Clk);
        bus.CmdValid   = 1'b0;
    endtask

    task automatic wait_start(input logic modmul, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (modmul ? bus.ModMulStart : bus.BasicStart) begin
                found = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        check(tag, found, 1'b1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rdy"},   bus.CmdReady, 1'b1);
        check({tag, "_busy"},  bus.Busy, 1'b0);
        check({tag, "_start"}, {bus.BasicStart, bus.ModMulStart}, 2'b00);
        check({tag, "_adr"},   {bus.EngOp, bus.Src0Adr, bus.Src1Adr, bus.DstAdr}, 30'h0);
        check({tag, "_flags"}, {bus.OpDone, bus.ErrSpur, bus.ErrTmo,
                                bus.RsaMode, bus.ExpMode, bus.MimmMode}, 6'h0);
    endtask

    initial begin
        int b0, m0, d0, t_a, t_b;
        Resetn         = 1'b0;
        bus.CmdValid   = 1'b0;
        bus.CmdOp      = '0;
        bus.CmdSrc0Adr = '0;
        bus.CmdSrc1Adr = '0;
        bus.CmdDstAdr  = '0;
        bus.CmdRsa     = 1'b0;
        bus.CmdExp     = 1'b0;
        bus.CmdMimm    = 1'b0;
        bus.BasicDone  = 1'b0;
        bus.ModMulDone = 1'b0;
        bus.Abort      = 1'b0;
        bus.ErrClr     = 1'b0;
        repeat (3) @(negedge Clk);
        check_idle_outputs("reset");
        Resetn = 1'b1;
        @(negedge Clk);
        check_idle_outputs("post_reset");

        // Single Basic op, Done 5 cycles after start
        b0 = n_bstart; m0 = n_mstart; d0 = n_opdone;
        push(4'h1, 9'h010, 9'h020, 9'h030);
        wait_start(1'b0, "basic_start_seen");
        check("basic_latch", {bus.EngOp, bus.Src0Adr, bus.Src1Adr, bus.DstAdr},
              {3'h1, 9'h010, 9'h020, 9'h030});
        repeat (5) @(negedge Clk);
        check("src0_held", bus.Src0Adr, 9'h010);
        check("no_early_opdone", bus.OpDone, 1'b0);
        bus.BasicDone = 1'b1;
        @(negedge Clk);
        bus.BasicDone = 1'b0;
        check("opdone_after_done", bus.OpDone, 1'b1);
        @(negedge Clk);
        check("opdone_one_cycle", bus.OpDone, 1'b0);
        check("idle_after_op", bus.Busy, 1'b0);
        check("single_bstart", n_bstart - b0, 1);
        check("no_mstart", n_mstart - m0, 0);
        check("one_opdone", n_opdone - d0, 1);

        // Back-to-back Basic then ModMul; FIFO fills at two entries
        push(4'h3, 9'h101, 9'h102, 9'h103);
        push(4'hA, 9'h1FF, 9'h0AA, 9'h155);
        check("full_not_ready", bus.CmdReady, 1'b0);
        wait_start(1'b0, "b2b_basic_start");
        t_a = cyc;
        check("b2b_basic_op", bus.EngOp, 3'h3);
        @(negedge Clk);
        bus.BasicDone = 1'b1;
        @(negedge Clk);
        bus.BasicDone = 1'b0;
        check("b2b_opdone1", bus.OpDone, 1'b1);
        wait_start(1'b1, "b2b_modmul_start");
        t_b = cyc;
        check("start_spacing_ge4", (t_b - t_a) >= 4, 1'b1);
        check("modmul_latch", {bus.EngOp, bus.Src0Adr, bus.Src1Adr, bus.DstAdr},
              {3'h2, 9'h1FF, 9'h0AA, 9'h155});

        // Wrong-engine Done while waiting on ModMul
        @(negedge Clk);
        bus.BasicDone = 1'b1;
        @(negedge Clk);
        bus.BasicDone = 1'b0;
        check("spur_set", bus.ErrSpur, 1'b1);
        check("spur_no_opdone", bus.OpDone, 1'b0);
        check("spur_still_busy", bus.Busy, 1'b1);
        bus.ModMulDone = 1'b1;
        @(negedge Clk);
        bus.ModMulDone = 1'b0;
        check("modmul_opdone", bus.OpDone, 1'b1);
        bus.ErrClr = 1'b1;
        @(negedge Clk);
        bus.ErrClr = 1'b0;
        check("spur_cleared", bus.ErrSpur, 1'b0);

        // Abort during first WAIT with a second command queued; coincident Done loses
        @(negedge Clk);
        push(4'h2, 9'h011, 9'h012, 9'h013);
        push(4'h9, 9'h021, 9'h022, 9'h023);
        wait_start(1'b0, "abort_basic_start");
        @(negedge Clk);
        b0 = n_bstart; m0 = n_mstart; d0 = n_opdone;
        bus.Abort     = 1'b1;
        bus.BasicDone = 1'b1;
        #1;
        check("abort_not_ready", bus.CmdReady, 1'b0);
        @(negedge Clk);
        bus.Abort     = 1'b0;
        bus.BasicDone = 1'b0;
        check("abort_idle", bus.Busy, 1'b0);
        check("abort_no_opdone", bus.OpDone, 1'b0);
        repeat (10) @(negedge Clk);
        check("abort_no_start", (n_bstart - b0) + (n_mstart - m0), 0);
        check("abort_no_opdone_cnt", n_opdone - d0, 0);
        check("abort_ready", bus.CmdReady, 1'b1);

        // Done outside WAIT, then set-beats-clear
        bus.ModMulDone = 1'b1;
        @(negedge Clk);
        bus.ModMulDone = 1'b0;
        check("idle_done_spur", bus.ErrSpur, 1'b1);
        bus.BasicDone = 1'b1;
        bus.ErrClr    = 1'b1;
        @(negedge Clk);
        bus.BasicDone = 1'b0;
        check("set_wins_clear", bus.ErrSpur, 1'b1);
        @(negedge Clk);
        bus.ErrClr = 1'b0;
        check("clear_alone", bus.ErrSpur, 1'b0);

        // Reset asserted mid-WAIT
        push(4'hC, 9'h0F0, 9'h0F1, 9'h0F2);
        wait_start(1'b1, "rst_modmul_start");
        @(negedge Clk);
        b0 = n_bstart; m0 = n_mstart;
        Resetn = 1'b0;
        #1;
        check_idle_outputs("rst_in_wait");
        @(negedge Clk);
        Resetn = 1'b1;
        check_idle_outputs("rst_release");
        repeat (8) @(negedge Clk);
        check("rst_dropped_op", (n_bstart - b0) + (n_mstart - m0), 0);

`ifdef PKE_SEQ_TIMEOUT_EN
        // No Done: timeout after 16 WAIT cycles, next command proceeds
        d0 = n_opdone;
        push(4'h1, 9'h001, 9'h002, 9'h003);
        push(4'h8, 9'h004, 9'h005, 9'h006);
        wait_start(1'b0, "tmo_basic_start");
        repeat (16) @(negedge Clk);
        check("tmo_not_yet", bus.ErrTmo, 1'b0);
        @(negedge Clk);
        check("tmo_set", bus.ErrTmo, 1'b1);
        check("tmo_no_opdone", bus.OpDone, 1'b0);
        wait_start(1'b1, "tmo_next_start");
        check("tmo_opdone_cnt", n_opdone - d0, 0);
        @(negedge Clk);
        bus.ModMulDone = 1'b1;
        @(negedge Clk);
        bus.ModMulDone = 1'b0;
        check("tmo_next_opdone", bus.OpDone, 1'b1);
        check("tmo_sticky", bus.ErrTmo, 1'b1);
        bus.ErrClr = 1'b1;
        @(negedge Clk);
        bus.ErrClr = 1'b0;
        check("tmo_cleared", bus.ErrTmo, 1'b0);
`else
        push(4'h1, 9'h001, 9'h002, 9'h003);
        wait_start(1'b0, "notmo_start");
        repeat (40) @(negedge Clk);
        check("notmo_still_busy", bus.Busy, 1'b1);
        check("notmo_errtmo_zero", bus.ErrTmo, 1'b0);
        bus.BasicDone = 1'b1;
        @(negedge Clk);
        bus.BasicDone = 1'b0;
        check("notmo_opdone", bus.OpDone, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
